// File: rtl/game_status.sv
// game_status: LED sweep reaction game core with BCD score, levels and 7-segment digits
module game_status #(
  parameter int STEP_CYCLES = 8,
  parameter int MAX_LEVEL   = 3
) (
  input  logic       clock,
  input  logic       start,
  input  logic [9:0] switch,
  output logic [9:0] led,
  output logic [6:0] point_msb,
  output logic [6:0] point_lsb,
  output logic [6:0] level_out,
  output logic       splitter
);
  localparam int CW = $clog2(STEP_CYCLES + 1);
  typedef enum logic [3:0] {OVER = 4'd0, READY = 4'd1, RUN = 4'd2, LEVEL_UP = 4'd3} state_t;
  state_t _current, current_d;
  logic [9:0] led_q, led_d;
  logic [3:0] tens_q, tens_d, ones_q, ones_d, level_q, level_d;
  logic [CW-1:0] count_q, count_d, last;
  logic step, sat;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction
  // next-state: sweep timing, hit scoring and level progression
  always_comb begin
    last = CW'((STEP_CYCLES >> (level_q - 4'd1)) - 1);
    step = (_current == RUN) && (count_q == last);
    sat = (tens_q == 4'd9) && (ones_q == 4'd9);
    current_d = _current;
    led_d = led_q;
    tens_d = tens_q;
    ones_d = ones_q;
    level_d = level_q;
    count_d = count_q;
    case (_current)
      READY: begin
        led_d = 10'h200;
        count_d = '0;
        current_d = RUN;
      end
      RUN: begin
        count_d = step ? '0 : count_q + 1'b1;
        if (step && switch == led_q && !sat) begin
          ones_d = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
          tens_d = (ones_q == 4'd9) ? tens_q + 4'd1 : tens_q;
        end
        if (step) begin
          led_d = (led_q == 10'd1) ? led_q : led_q >> 1;
          current_d = (led_q == 10'd1) ? LEVEL_UP : RUN;
        end
      end
      LEVEL_UP: begin
        if (level_q == 4'(MAX_LEVEL)) begin
          led_d = 10'h3FF;
          current_d = OVER;
        end else begin
          level_d = level_q + 4'd1;
          led_d = 10'h200;
          count_d = '0;
          current_d = RUN;
        end
      end
      default: current_d = OVER;
    endcase
  end
  // state registers, cleared to the ready state while start is held
  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      _current <= READY;
      led_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
      level_q <= 4'd1;
      count_q <= '0;
    end else begin
      _current <= current_d;
      led_q <= led_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      level_q <= level_d;
      count_q <= count_d;
    end
  end
  assign led = led_q;
  assign splitter = step;
  assign point_msb = seg(tens_q);
  assign point_lsb = seg(ones_q);
  assign level_out = seg(level_q);
endmodule

// File: tb/tb_game_status.sv
// tb_game_status: directed games with a scoreboard of expected end-of-game results
module tb_game_status;
  logic clock = 0, start = 1;
  logic [9:0] switch = '0, led;
  logic [6:0] point_msb, point_lsb, level_out;
  logic splitter;
  int errors = 0, checks = 0;
  int over_at, splits, l2, l3;
  typedef struct {string tag; logic [9:0] led; logic [6:0] msb, lsb;} exp_t;
  exp_t sb[$];
  exp_t e;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S6 = 7'b0000010, S9 = 7'b0010000;
  game_status dut (
    .clock(clock), .start(start), .switch(switch), .led(led),
    .point_msb(point_msb), .point_lsb(point_lsb), .level_out(level_out), .splitter(splitter)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic play(input int mode, input int stop_at, output int ov, output int sp, output int a2, output int a3);
    ov = -1; sp = 0; a2 = -1; a3 = -1;
    start = 1;
    switch = (mode == 0) ? 10'h0 : 10'h200;
    repeat (2) @(negedge clock);
    start = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clock);
      if (splitter) sp++;
      if (level_out == S2 && a2 < 0) a2 = n;
      if (level_out == S3 && a3 < 0) a3 = n;
      if (dut._current == 4'd0 && ov < 0) ov = n;
      if (n == stop_at || (ov > 0 && n == ov + 5)) break;
      case (mode)
        0: switch = 10'h0;
        1: switch = 10'h200;
        2: switch = (led == 10'h8 || led == 10'h2) ? led : 10'h200;
        default: switch = led;
      endcase
    end
  endtask
  task automatic finish_game(input string tag);
    e = sb.pop_front();
    chk({tag, "_over_cycle"}, over_at, 144);
    chk({tag, "_splits"}, splits, 30);
    chk({tag, "_level2_cycle"}, l2, 82);
    chk({tag, "_level3_cycle"}, l3, 123);
    chk({tag, "_state"}, dut._current, 0);
    chk({tag, "_led"}, led, e.led);
    chk({tag, "_msb"}, point_msb, e.msb);
    chk({tag, "_lsb"}, point_lsb, e.lsb);
    chk({tag, "_level"}, level_out, S3);
    chk({tag, "_splitter"}, splitter, 0);
  endtask
  initial begin
    repeat (8) @(negedge clock);
    chk("rst_led", led, 0);
    chk("rst_msb", point_msb, S0);
    chk("rst_lsb", point_lsb, S0);
    chk("rst_level", level_out, S1);
    chk("rst_state", dut._current, 1);
    chk("rst_splitter", splitter, 0);
    start = 0;
    @(negedge clock);
    chk("first_led", led, 10'h200);
    chk("first_state", dut._current, 2);
    sb.push_back('{"miss", 10'h3FF, S0, S0});
    play(0, 0, over_at, splits, l2, l3);
    finish_game("miss");
    sb.push_back('{"hold200", 10'h3FF, S0, S3});
    play(1, 0, over_at, splits, l2, l3);
    finish_game("hold200");
    sb.push_back('{"three_pos", 10'h3FF, S0, S9});
    play(2, 0, over_at, splits, l2, l3);
    finish_game("three_pos");
    sb.push_back('{"follow", 10'h3FF, S3, S0});
    play(3, 0, over_at, splits, l2, l3);
    finish_game("follow");
    play(3, 50, over_at, splits, l2, l3);
    chk("mid_lsb", point_lsb, S6);
    chk("mid_level", level_out, S1);
    #2 start = 1;
    #1;
    chk("async_led", led, 0);
    chk("async_lsb", point_lsb, S0);
    chk("async_msb", point_msb, S0);
    chk("async_level", level_out, S1);
    chk("async_state", dut._current, 1);
    sb.push_back('{"restart", 10'h3FF, S0, S3});
    play(1, 0, over_at, splits, l2, l3);
    finish_game("restart");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
